arb4_rr_stage: RTL and testbench
================================

ARB4_RR_STAGE -- requirements
Module: arb4_rr_stage

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width of every requester and of the output.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports in_valid, input, 4, where bit i means requester i presents data.
REQ-005 The block SHALL have ports in_data0..in_data3, input, N each, the requester payloads.
REQ-006 The block SHALL have port in_ready, output, 4, where bit i means requester i is accepted this cycle.
REQ-007 The block SHALL have port out_valid, output, 1, registered output holds a valid word.
REQ-008 The block SHALL have port out_data, output, N, the registered granted payload.
REQ-009 The block SHALL have port out_sel, output, 2, the registered index of the granted requester, suitable as the select of a downstream 4:1 mux.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream consumer accepts out_data this cycle.

Function
REQ-011 Load condition SHALL be load = |in_valid & (!out_valid | out_ready).
REQ-012 The grant SHALL go to the first set in_valid bit searched from index ptr upward, modulo 4 (ptr, ptr+1, ptr+2, ptr+3).
REQ-013 in_ready SHALL be one-hot at the granted index when load is 1, and 4'b0000 otherwise; it is combinational from in_valid, out_valid, out_ready, ptr.
REQ-014 On a clock edge with load=1, the block SHALL set out_valid=1, out_data=granted payload, out_sel=granted index, and ptr=(granted index+1) mod 4.
REQ-015 On an edge with out_valid=1, out_ready=1, in_valid=0, the block SHALL clear out_valid and hold out_data, out_sel, ptr.
REQ-016 On an edge with out_valid=1, out_ready=0 (stall), the block SHALL hold out_valid, out_data, out_sel, ptr unchanged, with in_ready=0.
REQ-017 Latency SHALL be one cycle from acceptance (in_ready[i]=1) to out_valid=1; sustained throughput SHALL be one word per cycle when out_ready stays 1.
REQ-018 Simultaneous drain and load (out_valid=1, out_ready=1, any in_valid) SHALL replace the output word in the same edge with no bubble.
REQ-019 Requesters SHALL hold in_valid and payload stable until in_ready; the block SHALL never drop or duplicate an accepted word.
REQ-020 ptr SHALL wrap from 3 to 0 (granted index 3 sets ptr=0).

Reset
REQ-021 rst_n=0 SHALL immediately force out_valid=0, out_data=0, out_sel=2'b00, ptr=0, independent of clk.
REQ-022 A word held in the output register when reset asserts SHALL be discarded; in_ready SHALL be 0 while rst_n=0.
REQ-023 The first edge after rst_n deasserts SHALL behave as a normal cycle from the reset state.

Configuration
REQ-024 Macro ARB4_RR_STAGE_RR_EN SHALL select the arbitration policy at compile time.
REQ-025 With ARB4_RR_STAGE_RR_EN defined, the block SHALL use rotating priority per REQ-012/REQ-014.
REQ-026 Without ARB4_RR_STAGE_RR_EN, ptr SHALL be held at 0 permanently (fixed priority, index 0 highest); all other requirements SHALL be unchanged.

Verification
REQ-027 Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_sel=0, out_data=0 within the same cycle, no clk edge needed.
REQ-028 Rotation (RR_EN): in_valid=4'b1111 held, out_ready=1, payloads 0xA0..0xA3 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
REQ-029 Skip and wrap: ptr=3 after grant of 2, in_valid=4'b0011 -> grant 0, then ptr=1, next grant 1.
REQ-030 Stall: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0100 -> in_ready=0, out_data/out_sel stable; out_ready=1 -> in_ready=4'b0100 same cycle, new word next edge.
REQ-031 Drain to empty: one word 0x55 from requester 1, then in_valid=0, out_ready=1 -> out_valid 1 for exactly one cycle, then 0.
REQ-032 Fixed priority (macro undefined): in_valid=4'b1010 held, out_ready=1 -> out_sel=1 every cycle, requester 3 never granted.

Source files
------------

// File: rtl/arb4_rr_stage.sv
// 4-requester arbiter feeding a one-deep registered output stage.
// ARB4_RR_STAGE_RR_EN selects rotating priority; otherwise index 0 wins.
module arb4_rr_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [N-1:0] in_data0,
  input  logic [N-1:0] in_data1,
  input  logic [N-1:0] in_data2,
  input  logic [N-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  logic [1:0]   ptr_q, ptr_d;
  logic         vld_q, vld_d;
  logic [N-1:0] data_q, data_d;
  logic [1:0]   sel_q, sel_d;

  logic [1:0]   gnt_idx;
  logic [1:0]   idx;
  logic         found;
  logic [N-1:0] gnt_data;
  logic         load;

  // first valid requester searching upward from ptr, wrapping at 3
  always_comb begin
    gnt_idx = ptr_q;
    idx     = 2'd0;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + k[1:0];
      if (!found && in_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_data = in_data0;
    unique case (gnt_idx)
      2'd0: gnt_data = in_data0;
      2'd1: gnt_data = in_data1;
      2'd2: gnt_data = in_data2;
      2'd3: gnt_data = in_data3;
    endcase
  end

  assign load = rst_n & (|in_valid) & (~vld_q | out_ready);

  always_comb begin
    in_ready = 4'b0000;
    if (load) in_ready = 4'b0001 << gnt_idx;
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = gnt_data;
      sel_d  = gnt_idx;
    end else if (out_ready) begin
      vld_d  = 1'b0;
    end
  end

`ifdef ARB4_RR_STAGE_RR_EN
  assign ptr_d = load ? gnt_idx + 2'd1 : ptr_q;
`else
  assign ptr_d = 2'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= 2'd0;
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= 2'd0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb4_rr_stage.sv
// Directed bench for arb4_rr_stage with a cycle model and literal checks.
// Follows ARB4_RR_STAGE_RR_EN to pick the expected arbitration policy.
module tb_arb4_rr_stage;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [N-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  // model state
  logic         m_valid;
  logic [N-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  arb4_rr_stage #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] payload(input int i);
    case (i)
      0: return in_data0;
      1: return in_data1;
      2: return in_data2;
      default: return in_data3;
    endcase
  endfunction

  // index that wins, or -1 when nothing may be accepted
  function automatic int exp_grant();
    if (rst_n !== 1'b1) return -1;
    if (in_valid == 4'b0) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  always @(negedge rst_n) begin
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  end

  always @(posedge clk) begin
    int g;
    if (rst_n === 1'b1) begin
      g = exp_grant();
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = payload(g);
        m_sel   = g;
`ifdef ARB4_RR_STAGE_RR_EN
        m_ptr   = (g + 1) % 4;
`endif
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_in_ready", N'(in_ready), N'(exp_ready()));
    chk("cyc_out_valid", N'(out_valid), N'(m_valid));
    chk("cyc_out_data", out_data, m_data);
    chk("cyc_out_sel", N'(out_sel), N'(m_sel));
  end

  task automatic set(input logic [3:0] v, input logic r);
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] held_sel;
  int         vcount;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0;
    out_ready = 1'b0;
    in_data0  = 32'hA0;
    in_data1  = 32'hA1;
    in_data2  = 32'hA2;
    in_data3  = 32'hA3;
    #1;
    chk("rst_out_valid", N'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", N'(in_ready), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

`ifdef ARB4_RR_STAGE_RR_EN
    set(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rot_sel", N'(out_sel), N'(i % 4));
      chk("rot_data", out_data, N'(32'hA0 + (i % 4)));
    end
`else
    set(4'b1010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fix_sel", N'(out_sel), N'(1));
      chk("fix_data", out_data, N'(32'hA1));
    end
`endif

    set(4'b0100, 1'b1);
    tick();
    chk("skip_g2", N'(out_sel), N'(2));
    set(4'b0011, 1'b1);
    tick();
    chk("wrap_g0", N'(out_sel), N'(0));
    tick();
`ifdef ARB4_RR_STAGE_RR_EN
    chk("wrap_g1", N'(out_sel), N'(1));
`else
    chk("fix_g0", N'(out_sel), N'(0));
`endif

    held_sel = out_sel;
    set(4'b0100, 1'b0);
    #1;
    chk("stall_ready", N'(in_ready), '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", N'(out_valid), N'(1));
      chk("stall_sel", N'(out_sel), N'(held_sel));
      chk("stall_ready", N'(in_ready), '0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_ready", N'(in_ready), N'(4'b0100));
    tick();
    chk("unstall_sel", N'(out_sel), N'(2));
    chk("unstall_data", out_data, N'(32'hA2));

    in_data1 = 32'h55;
    set(4'b0010, 1'b1);
    tick();
    set(4'b0000, 1'b1);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      if (out_valid) vcount++;
    end
    chk("drain_cycles", N'(vcount), N'(1));
    chk("drain_hold", out_data, N'(32'h55));

    set(4'b1111, 1'b1);
    tick();
    chk("pre_rst_valid", N'(out_valid), N'(1));
    rst_n = 1'b0;
    #1;
    chk("async_valid", N'(out_valid), '0);
    chk("async_sel", N'(out_sel), '0);
    chk("async_data", out_data, '0);
    chk("async_ready", N'(in_ready), '0);
    set(4'b1000, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel", N'(out_sel), N'(3));
    chk("post_rst_data", out_data, N'(32'hA3));
    set(4'b1001, 1'b1);
    tick();
    chk("ptr_wrap_sel", N'(out_sel), N'(0));
    set(4'b0000, 1'b0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
